us_ip_tx: RTL and testbench

IPv4 transmit encapsulator directly downstream of `us_udp_tx`. It consumes complete UDP datagrams (8-byte UDP header followed by payload) on a 64-bit AXI-Stream. It prepends a 20-byte IPv4 header (protocol 17), computing total length, identification and header checksum. The result goes out as a 64-bit AXI-Stream IP packet to the Ethernet framer.

---
 rtl/us_net_pkg.sv | 37 +++
 rtl/us_ip_csum.sv | 41 ++++
 rtl/us_ip_tx.sv | 169 ++++++++++++++++
 tb/tb_us_ip_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/us_net_pkg.sv
// Shared IPv4/UDP transmit definitions: header constants, header-word record,
// encapsulator FSM states and wire byte-order helpers.
package us_net_pkg;

  localparam logic [3:0]  IP_VERSION   = 4'h4;
  localparam logic [3:0]  IP_IHL       = 4'h5;
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;
  localparam int          IP_HDR_BYTES = 20;
  localparam logic [7:0]  PROTO_UDP    = 8'd17;

  typedef struct packed {
    logic [15:0] ver_ihl_tos;
    logic [15:0] total_len;
    logic [15:0] ident;
    logic [15:0] flags_frag;
    logic [15:0] ttl_proto;
    logic [15:0] csum;
    logic [15:0] src_hi;
    logic [15:0] src_lo;
    logic [15:0] dst_hi;
    logic [15:0] dst_lo;
  } ip_hdr_words_t;

  typedef enum logic [2:0] {
    IDLE, SUM, FOLD, HDR0, HDR1, HDR2, BODY, TAIL
  } ip_tx_state_t;

  // Lane 0 is the first byte on the wire, so big-endian fields are byte-swapped into lanes.
  function automatic logic [15:0] be16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] be32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/us_ip_csum.sv
// Two-stage ones'-complement sum/fold over the ten IPv4 header words;
// produces the inverted header checksum two cycles after the words settle.
module us_ip_csum
  import us_net_pkg::*;
(
  input  logic          clk,
  input  ip_hdr_words_t words,
  output logic [15:0]   csum
);

  logic [19:0] sum_p0;
  logic [15:0] csum_p1;

  function automatic logic [19:0] add_words(input ip_hdr_words_t w);
    return 20'(w.ver_ihl_tos) + 20'(w.total_len) + 20'(w.ident) + 20'(w.flags_frag)
         + 20'(w.ttl_proto) + 20'(w.csum) + 20'(w.src_hi) + 20'(w.src_lo)
         + 20'(w.dst_hi) + 20'(w.dst_lo);
  endfunction

  // Two folds are enough: ten 16-bit words cannot carry past bit 19.
  function automatic logic [15:0] fold(input logic [19:0] s);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = {1'b0, s[15:0]} + {13'b0, s[19:16]};
    f2 = f1[15:0] + {15'b0, f1[16]};
    return f2;
  endfunction

  // stage p0: wide sum
  always_ff @(posedge clk) begin
    sum_p0 <= add_words(words);
  end

  // stage p1: fold and invert
  always_ff @(posedge clk) begin
    csum_p1 <= ~fold(sum_p0);
  end

  assign csum = csum_p1;

endmodule

// File: rtl/us_ip_tx.sv
// IPv4 transmit encapsulator: prepends a 20-byte IPv4 header to UDP datagrams.
// Define US_IP_TX_CHECKSUM_EN to compute the header checksum; otherwise it is sent as zero.
module us_ip_tx
  import us_net_pkg::*;
#(
  parameter logic [7:0] TTL      = 8'd64,
  parameter logic [7:0] PROTOCOL = PROTO_UDP
) (
  input  logic        tx_axis_aclk,
  input  logic        tx_axis_aresetn,
  input  logic [31:0] src_ip_addr,
  input  logic [31:0] dst_ip_addr,
  input  logic [63:0] ip_tx_axis_tdata,
  input  logic [7:0]  ip_tx_axis_tkeep,
  input  logic        ip_tx_axis_tvalid,
  input  logic        ip_tx_axis_tlast,
  output logic        ip_tx_axis_tready,
  output logic [63:0] mac_tx_axis_tdata,
  output logic [7:0]  mac_tx_axis_tkeep,
  output logic        mac_tx_axis_tvalid,
  output logic        mac_tx_axis_tlast,
  input  logic        mac_tx_axis_tready
);

  ip_tx_state_t state, state_n;

  logic [63:0] hold;
  logic [3:0]  hold_keep_hi;
  logic        hold_last;
  logic [15:0] udp_len;
  logic [31:0] src_q, dst_q;
  logic [15:0] ip_id;
  logic [15:0] total_len;
  logic [15:0] csum;

  logic        out_free, in_ready, in_fire;
  logic        load, ld_last;
  logic [63:0] ld_data;
  logic [7:0]  ld_keep;

  assign total_len         = udp_len + 16'(IP_HDR_BYTES);
  assign out_free          = !mac_tx_axis_tvalid || mac_tx_axis_tready;
  assign in_fire           = ip_tx_axis_tvalid && in_ready;
  assign ip_tx_axis_tready = tx_axis_aresetn && in_ready;

`ifdef US_IP_TX_CHECKSUM_EN
  ip_hdr_words_t hdr_words;

  assign hdr_words = '{
    ver_ihl_tos: {IP_VERSION, IP_IHL, 8'h00},
    total_len:   total_len,
    ident:       ip_id,
    flags_frag:  IP_FLAGS_DF,
    ttl_proto:   {TTL, PROTOCOL},
    csum:        16'h0000,
    src_hi:      src_q[31:16],
    src_lo:      src_q[15:0],
    dst_hi:      dst_q[31:16],
    dst_lo:      dst_q[15:0]
  };

  us_ip_csum u_csum (
    .clk   (tx_axis_aclk),
    .words (hdr_words),
    .csum  (csum)
  );
`else
  assign csum = 16'h0000;
`endif

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    load     = 1'b0;
    ld_data  = '0;
    ld_keep  = '0;
    ld_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (ip_tx_axis_tvalid) state_n = SUM;
      end
      // Hold here while the previous packet's final beat is pending, so ip_id is
      // settled before it enters the checksum.
      SUM: if (!mac_tx_axis_tvalid) state_n = FOLD;
      FOLD: state_n = HDR0;
      HDR0: if (out_free) begin
        load    = 1'b1;
        ld_data = {be16(IP_FLAGS_DF), be16(ip_id), be16(total_len),
                   be16({IP_VERSION, IP_IHL, 8'h00})};
        ld_keep = 8'hFF;
        state_n = HDR1;
      end
      HDR1: if (out_free) begin
        load    = 1'b1;
        ld_data = {be32(src_q), be16(csum), be16({TTL, PROTOCOL})};
        ld_keep = 8'hFF;
        state_n = HDR2;
      end
      HDR2: if (out_free) begin
        load    = 1'b1;
        ld_data = {hold[31:0], be32(dst_q)};
        ld_keep = 8'hFF;
        state_n = hold_last ? TAIL : BODY;
      end
      BODY: begin
        in_ready = out_free;
        if (ip_tx_axis_tvalid && out_free) begin
          load    = 1'b1;
          ld_data = {ip_tx_axis_tdata[31:0], hold[63:32]};
          ld_keep = {ip_tx_axis_tkeep[3:0], 4'hF};
          if (ip_tx_axis_tlast) begin
            if (ip_tx_axis_tkeep[7:4] == 4'h0) begin
              ld_last = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = TAIL;
            end
          end
        end
      end
      TAIL: if (out_free) begin
        load    = 1'b1;
        ld_data = {32'h0, hold[63:32]};
        ld_keep = {4'h0, hold_keep_hi};
        ld_last = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (!tx_axis_aresetn) begin
      state              <= IDLE;
      mac_tx_axis_tvalid <= 1'b0;
      mac_tx_axis_tdata  <= '0;
      mac_tx_axis_tkeep  <= '0;
      mac_tx_axis_tlast  <= 1'b0;
      ip_id              <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        mac_tx_axis_tvalid <= 1'b1;
        mac_tx_axis_tdata  <= ld_data;
        mac_tx_axis_tkeep  <= ld_keep;
        mac_tx_axis_tlast  <= ld_last;
      end else if (mac_tx_axis_tready) begin
        mac_tx_axis_tvalid <= 1'b0;
      end
      if (mac_tx_axis_tvalid && mac_tx_axis_tready && mac_tx_axis_tlast)
        ip_id <= ip_id + 16'd1;
    end
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (in_fire) begin
      hold         <= ip_tx_axis_tdata;
      hold_keep_hi <= ip_tx_axis_tkeep[7:4];
      if (state == IDLE) begin
        hold_last <= ip_tx_axis_tlast;
        udp_len   <= {ip_tx_axis_tdata[39:32], ip_tx_axis_tdata[47:40]};
        src_q     <= src_ip_addr;
        dst_q     <= dst_ip_addr;
      end
    end
  end

endmodule

// File: tb/tb_us_ip_tx.sv
// Scoreboard bench for us_ip_tx: a byte-level IPv4 packet model feeds an expected-beat
// queue that an independent output monitor drains and compares.
`timescale 1ns/1ps
module tb_us_ip_tx;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] src_ip, dst_ip;
  logic [63:0] in_tdata;
  logic [7:0]  in_tkeep;
  logic        in_tvalid, in_tlast, in_tready;
  logic [63:0] mac_tdata;
  logic [7:0]  mac_tkeep;
  logic        mac_tvalid, mac_tlast, mac_tready;

  us_ip_tx dut (
    .tx_axis_aclk       (clk),
    .tx_axis_aresetn    (rstn),
    .src_ip_addr        (src_ip),
    .dst_ip_addr        (dst_ip),
    .ip_tx_axis_tdata   (in_tdata),
    .ip_tx_axis_tkeep   (in_tkeep),
    .ip_tx_axis_tvalid  (in_tvalid),
    .ip_tx_axis_tlast   (in_tlast),
    .ip_tx_axis_tready  (in_tready),
    .mac_tx_axis_tdata  (mac_tdata),
    .mac_tx_axis_tkeep  (mac_tkeep),
    .mac_tx_axis_tvalid (mac_tvalid),
    .mac_tx_axis_tlast  (mac_tlast),
    .mac_tx_axis_tready (mac_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    bit          lat;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          in_beats = 0;
  bit          abort = 0;
  int          rdy_mode = 0;
  logic [15:0] next_id = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mac_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       mac_tready = 1'b1;
        1:       mac_tready = ~mac_tready;
        default: mac_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference: the IP packet is the header bytes followed by the UDP bytes, cut into 8-byte beats.
  function automatic void push_expected(input byte unsigned udp[$], input logic [31:0] s,
                                        input logic [31:0] d, input logic [15:0] id, input bit lat);
    byte unsigned ip[$];
    logic [15:0]  w[10];
    logic [15:0]  tl, ck;
    int unsigned  sum;
    beat_t        e;
    tl = {udp[4], udp[5]} + 16'd20;
    w = '{16'h4500, tl, id, 16'h4000, 16'h4011, 16'h0000, s[31:16], s[15:0], d[31:16], d[15:0]};
    sum = 0;
    foreach (w[i]) sum += w[i];
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
`ifdef US_IP_TX_CHECKSUM_EN
    ck = ~16'(sum);
`else
    ck = 16'h0000;
`endif
    w[5] = ck;
    foreach (w[i]) begin
      ip.push_back(w[i][15:8]);
      ip.push_back(w[i][7:0]);
    end
    foreach (udp[i]) ip.push_back(udp[i]);
    for (int i = 0; i < ip.size(); i += 8) begin
      e.data = '0;
      e.keep = '0;
      for (int k = 0; k < 8; k++) begin
        if (i + k < ip.size()) begin
          e.data[8*k +: 8] = ip[i+k];
          e.keep[k] = 1'b1;
        end
      end
      e.last = (i + 8 >= ip.size());
      e.lat  = lat && (i == 0);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    beat_t       e;
    logic [63:0] m;
    if (rstn && mac_tvalid && mac_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got data=%h keep=%h last=%b expected no beat",
                 mac_tdata, mac_tkeep, mac_tlast);
      end else begin
        e = exp_q.pop_front();
        for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{e.keep[k]}};
        if ((mac_tdata & m) !== (e.data & m) || mac_tkeep !== e.keep || mac_tlast !== e.last) begin
          errors++;
          $display("FAIL beat got data=%h keep=%h last=%b expected data=%h keep=%h last=%b",
                   mac_tdata & m, mac_tkeep, mac_tlast, e.data & m, e.keep, e.last);
        end
        if (e.lat) begin
          checks++;
          if (cyc - acc_cyc != 3) begin
            errors++;
            $display("FAIL latency got=%0d expected=3", cyc - acc_cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic wait_hs(output bit ok);
    int n;
    n = 0;
    ok = 0;
    forever begin
      @(negedge clk);
      if (abort) return;
      if (in_tready) begin
        @(posedge clk);
        #1;
        ok = 1;
        return;
      end
      n++;
      if (n > 5000) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout got=no_ready expected=ready");
        return;
      end
    end
  endtask

  task automatic send_pkt(input logic [31:0] s, input logic [31:0] d, input int plen, input bit lat);
    byte unsigned udp[$];
    int           n, nb;
    bit           ok;
    logic [63:0]  dat;
    logic [7:0]   kp;
    n = 8 + plen;
    udp.push_back(8'($urandom));
    udp.push_back(8'($urandom));
    udp.push_back(8'($urandom));
    udp.push_back(8'($urandom));
    udp.push_back(8'(n >> 8));
    udp.push_back(8'(n));
    udp.push_back(8'($urandom));
    udp.push_back(8'($urandom));
    for (int i = 0; i < plen; i++) udp.push_back(8'($urandom));
    push_expected(udp, s, d, next_id, lat);
    next_id++;
    src_ip = s;
    dst_ip = d;
    nb = (n + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      dat = '0;
      kp  = '0;
      for (int k = 0; k < 8; k++) begin
        if (b*8 + k < n) begin
          dat[8*k +: 8] = udp[b*8 + k];
          kp[k] = 1'b1;
        end
      end
      in_tdata  = dat;
      in_tkeep  = kp;
      in_tlast  = (b == nb - 1);
      in_tvalid = 1'b1;
      wait_hs(ok);
      if (!ok) begin
        in_tvalid = 1'b0;
        return;
      end
      in_beats++;
      if (b == 0) acc_cyc = cyc;
    end
    in_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got_remaining=%0d expected=0", exp_q.size());
    end
  endtask

  initial begin
    in_tdata  = '0;
    in_tkeep  = '0;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    src_ip    = '0;
    dst_ip    = '0;
    rstn      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(mac_tvalid), 64'd0);
    chk("reset_tdata", mac_tdata, 64'd0);
    chk("reset_tkeep", 64'(mac_tkeep), 64'd0);
    chk("reset_tlast", 64'(mac_tlast), 64'd0);
    chk("reset_in_ready", 64'(in_tready), 64'd0);
    rstn = 1'b1;
    #1;
    chk("idle_in_ready", 64'(in_tready), 64'd1);

    send_pkt(32'hC0A8010A, 32'hC0A8010B, 80, 1);
    drain();
    send_pkt(32'hC0A8010A, 32'hC0A8010B, 0, 1);
    drain();
    send_pkt(32'hC0A80101, 32'h0A000001, 12, 1);
    drain();

    rdy_mode = 1;
    send_pkt(32'hC0A8010A, 32'hC0A8010B, 80, 0);
    send_pkt(32'hAC100001, 32'hAC100002, 37, 0);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 8; i++)
      send_pkt($urandom, $urandom, $urandom_range(0, 100), 0);
    drain();
    rdy_mode = 0;

    in_beats = 0;
    fork
      send_pkt(32'h0A000001, 32'h0A000002, 80, 0);
      begin
        int n;
        n = 0;
        while (in_beats < 4 && n < 2000) begin
          @(posedge clk);
          n++;
        end
        @(posedge clk);
        #1;
        rstn  = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_tvalid", 64'(mac_tvalid), 64'd0);
        chk("rst_mid_tdata", mac_tdata, 64'd0);
        chk("rst_mid_tkeep", 64'(mac_tkeep), 64'd0);
        chk("rst_mid_tlast", 64'(mac_tlast), 64'd0);
        chk("rst_mid_in_ready", 64'(in_tready), 64'd0);
      end
    join
    exp_q.delete();
    next_id = 16'h0000;
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    abort = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_tready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_quiet", 64'(mac_tvalid), 64'd0);

    send_pkt(32'hC0A8010A, 32'hC0A8010B, 80, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
